// File: rtl/sync_filter_multi_pkg.sv
// -----------------------------------------------------------------------------
// sync_filter_pkg
// Shared constants and helpers for the multi-channel input conditioner.
//   SYNC_MIN_STAGES : smallest legal synchroniser depth
//   GLITCH_CNT_W    : width of the optional rejected-pulse counter
//   cnt_width()     : width of the per-channel stability counter
// -----------------------------------------------------------------------------
package sync_filter_pkg;

  localparam int SYNC_MIN_STAGES = 2;
  localparam int GLITCH_CNT_W    = 16;

  // A filter length of 1 still needs a 1-bit counter so the port and
  // comparison widths stay legal.
  function automatic int cnt_width(input int filt_len);
    int w;
    w = $clog2(filt_len);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_filter_multi_ch.sv
// -----------------------------------------------------------------------------
// sync_filter_ch
// One channel of the input conditioner: flip-flop synchroniser, stability
// filter and registered rise/fall pulses.
// Optional build macro: SYNC_FILTER_GLITCH_CNT_EN adds the glitch output.
// Ports:
//   clk      : clock
//   rst      : asynchronous active-high reset
//   en       : filter enable (synchroniser always runs)
//   d_async  : raw asynchronous input
//   q        : synchronised, filtered level
//   rise     : one-cycle pulse when q goes 0->1
//   fall     : one-cycle pulse when q goes 1->0
//   edge_nxt : high when q will change on this edge (feeds any_edge)
//   glitch   : (macro only) a partial count is being discarded this edge
// -----------------------------------------------------------------------------
module sync_filter_ch
  import sync_filter_pkg::*;
#(
  parameter int   STAGES   = 3,
  parameter int   FILT_LEN = 4,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d_async,
  output logic q,
  output logic rise,
  output logic fall,
  output logic edge_nxt
`ifdef SYNC_FILTER_GLITCH_CNT_EN
  ,
  output logic glitch
`endif
);

  localparam int             CNT_W   = cnt_width(FILT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

  if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
    $error("sync_filter_ch: STAGES must be at least 2");
  end

  logic [STAGES-1:0] r_sync;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_q;
  logic              r_rise;
  logic              r_fall;
  logic              w_synced;
  logic              w_diff;
  logic              w_accept;

  assign w_synced = r_sync[STAGES-1];
  assign w_diff   = (w_synced != r_q);
  assign w_accept = en && w_diff && (r_cnt == CNT_MAX);

  // Synchroniser chain; deliberately not gated by en so metastability
  // settling continues while the filter is frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d_async};
    end
  end

  // Stability filter: q only follows synced after FILT_LEN consecutive
  // enabled edges of disagreement; any agreement discards the partial count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_q    <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (en) begin
        if (!w_diff) begin
          r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_q    <= w_synced;
          r_cnt  <= '0;
          r_rise <= w_synced;
          r_fall <= ~w_synced;
        end
      end
    end
  end

  assign q        = r_q;
  assign rise     = r_rise;
  assign fall     = r_fall;
  assign edge_nxt = w_accept;

`ifdef SYNC_FILTER_GLITCH_CNT_EN
  assign glitch = en && !w_diff && (r_cnt != '0);
`endif

endmodule

// File: rtl/sync_filter_multi.sv
// -----------------------------------------------------------------------------
// sync_filter_multi
// Multi-channel input conditioner for asynchronous sensor/control lines.
// Each channel is a sync_filter_ch; this level adds the registered any_edge
// summary and, when SYNC_FILTER_GLITCH_CNT_EN is defined, a saturating
// counter of rejected pulses.
// Ports:
//   clk        : clock
//   rst        : asynchronous active-high reset
//   en         : filter enable
//   d_async    : [N_CH] raw asynchronous inputs
//   q          : [N_CH] filtered levels
//   rise/fall  : [N_CH] one-cycle edge pulses
//   any_edge   : OR of rise|fall, aligned with them
//   glitch_clr : (macro only) synchronous clear of glitch_cnt
//   glitch_cnt : (macro only) [16] saturating rejected-pulse count
// -----------------------------------------------------------------------------
module sync_filter_multi
  import sync_filter_pkg::*;
#(
  parameter int              N_CH     = 16,
  parameter int              STAGES   = 3,
  parameter int              FILT_LEN = 4,
  parameter logic [N_CH-1:0] RST_VAL  = {N_CH{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N_CH-1:0] d_async,
  output logic [N_CH-1:0] q,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            any_edge
`ifdef SYNC_FILTER_GLITCH_CNT_EN
  ,
  input  logic                    glitch_clr,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

  logic [N_CH-1:0] w_edge_nxt;
  logic            r_any_edge;
`ifdef SYNC_FILTER_GLITCH_CNT_EN
  logic [N_CH-1:0]         w_glitch;
  logic [GLITCH_CNT_W-1:0] r_glitch_cnt;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sync_filter_ch #(
      .STAGES   (STAGES),
      .FILT_LEN (FILT_LEN),
      .RST_VAL  (RST_VAL[i])
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .d_async  (d_async[i]),
      .q        (q[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .edge_nxt (w_edge_nxt[i])
`ifdef SYNC_FILTER_GLITCH_CNT_EN
      ,
      .glitch   (w_glitch[i])
`endif
    );
  end

  // any_edge is built from the channels' next-edge flags so it lands in
  // the same cycle as the rise/fall registers it summarises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_any_edge <= 1'b0;
    end else begin
      r_any_edge <= |w_edge_nxt;
    end
  end

  assign any_edge = r_any_edge;

`ifdef SYNC_FILTER_GLITCH_CNT_EN
  // At most one count per cycle regardless of how many channels rejected
  // a pulse; clear wins over increment and the count saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_glitch_cnt <= '0;
    end else if (glitch_clr) begin
      r_glitch_cnt <= '0;
    end else if ((|w_glitch) && (r_glitch_cnt != {GLITCH_CNT_W{1'b1}})) begin
      r_glitch_cnt <= r_glitch_cnt + 1'b1;
    end
  end

  assign glitch_cnt = r_glitch_cnt;
`endif

endmodule

// File: tb/tb_sync_filter_multi.sv
// -----------------------------------------------------------------------------
// tb_sync_filter_multi
// Directed self-checking bench for sync_filter_multi with N_CH=4, STAGES=3,
// FILT_LEN=4, RST_VAL=0. Honours SYNC_FILTER_GLITCH_CNT_EN when defined.
// Edge E is the first rising edge after a stimulus change; the expected
// step latency is 6 edges after E.
// -----------------------------------------------------------------------------
module tb_sync_filter_multi;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] d_async;
  logic [3:0] q;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       any_edge;
`ifdef SYNC_FILTER_GLITCH_CNT_EN
  logic        glitch_clr;
  logic [15:0] glitch_cnt;
`endif

  int checks;
  int errors;

  sync_filter_multi #(
    .N_CH     (4),
    .STAGES   (3),
    .FILT_LEN (4),
    .RST_VAL  (4'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .d_async    (d_async),
    .q          (q),
    .rise       (rise),
    .fall       (fall),
    .any_edge   (any_edge)
`ifdef SYNC_FILTER_GLITCH_CNT_EN
    ,
    .glitch_clr (glitch_clr),
    .glitch_cnt (glitch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, leaving time 1 unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [3:0] expQ, expR, expF;
    logic       expA;
    rst = 1'b1;
    en = 1'b1;
    d_async = 4'hF;
    tick(3);
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL reset_q got %h want %h", q, 4'h0); end
    checks++; if (rise !== 4'h0) begin errors++; $display("FAIL reset_rise got %h want %h", rise, 4'h0); end
    checks++; if (fall !== 4'h0) begin errors++; $display("FAIL reset_fall got %h want %h", fall, 4'h0); end
    checks++; if (any_edge !== 1'b0) begin errors++; $display("FAIL reset_any got %b want 0", any_edge); end
`ifdef SYNC_FILTER_GLITCH_CNT_EN
    checks++; if (glitch_cnt !== 16'h0) begin errors++; $display("FAIL reset_gcnt got %h want 0", glitch_cnt); end
`endif
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      expQ = (c - 1 >= 6) ? 4'hF : 4'h0;
      expR = (c - 1 == 6) ? 4'hF : 4'h0;
      expA = (c - 1 == 6);
      checks++; if (q !== expQ) begin errors++; $display("FAIL exit_q e=%0d got %h want %h", c - 1, q, expQ); end
      checks++; if (rise !== expR) begin errors++; $display("FAIL exit_rise e=%0d got %h want %h", c - 1, rise, expR); end
      checks++; if (fall !== 4'h0) begin errors++; $display("FAIL exit_fall e=%0d got %h want 0", c - 1, fall); end
      checks++; if (any_edge !== expA) begin errors++; $display("FAIL exit_any e=%0d got %b want %b", c - 1, any_edge, expA); end
    end
    // Return every channel low and check the simultaneous falls.
    d_async = 4'h0;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      expQ = (c - 1 >= 6) ? 4'h0 : 4'hF;
      expF = (c - 1 == 6) ? 4'hF : 4'h0;
      checks++; if (q !== expQ) begin errors++; $display("FAIL allfall_q e=%0d got %h want %h", c - 1, q, expQ); end
      checks++; if (fall !== expF) begin errors++; $display("FAIL allfall_fall e=%0d got %h want %h", c - 1, fall, expF); end
      checks++; if (rise !== 4'h0) begin errors++; $display("FAIL allfall_rise e=%0d got %h want 0", c - 1, rise); end
    end
  endtask

  task automatic test_clean_step();
    logic [3:0] expQ, expR;
    logic       expA;
    d_async = 4'h1;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      expQ = (c - 1 >= 6) ? 4'h1 : 4'h0;
      expR = (c - 1 == 6) ? 4'h1 : 4'h0;
      expA = (c - 1 == 6);
      checks++; if (q !== expQ) begin errors++; $display("FAIL step_q e=%0d got %h want %h", c - 1, q, expQ); end
      checks++; if (rise !== expR) begin errors++; $display("FAIL step_rise e=%0d got %h want %h", c - 1, rise, expR); end
      checks++; if (fall !== 4'h0) begin errors++; $display("FAIL step_fall e=%0d got %h want 0", c - 1, fall); end
      checks++; if (any_edge !== expA) begin errors++; $display("FAIL step_any e=%0d got %b want %b", c - 1, any_edge, expA); end
    end
    d_async = 4'h0;
    tick(10);
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL step_settle_q got %h want 0", q); end
  endtask

  task automatic test_glitch();
    d_async = 4'h2;
    for (int c = 1; c <= 12; c++) begin
      tick(1);
      if (c == 3) d_async = 4'h0;
      checks++; if (q !== 4'h0) begin errors++; $display("FAIL glitch_q c=%0d got %h want 0", c, q); end
      checks++; if ((rise | fall) !== 4'h0) begin errors++; $display("FAIL glitch_pulse c=%0d got %h want 0", c, rise | fall); end
      checks++; if (any_edge !== 1'b0) begin errors++; $display("FAIL glitch_any c=%0d got %b want 0", c, any_edge); end
    end
`ifdef SYNC_FILTER_GLITCH_CNT_EN
    checks++; if (glitch_cnt !== 16'd1) begin errors++; $display("FAIL glitch_cnt got %0d want 1", glitch_cnt); end
    glitch_clr = 1'b1;
    tick(1);
    glitch_clr = 1'b0;
    checks++; if (glitch_cnt !== 16'd0) begin errors++; $display("FAIL glitch_clr got %0d want 0", glitch_cnt); end
`endif
  endtask

  task automatic test_boundary_pulse();
    logic [3:0] expQ, expR, expF;
    d_async = 4'h4;
    for (int c = 1; c <= 14; c++) begin
      tick(1);
      if (c == 4) d_async = 4'h0;
      expQ = ((c - 1 >= 6) && (c - 1 < 10)) ? 4'h4 : 4'h0;
      expR = (c - 1 == 6) ? 4'h4 : 4'h0;
      expF = (c - 1 == 10) ? 4'h4 : 4'h0;
      checks++; if (q !== expQ) begin errors++; $display("FAIL bound_q e=%0d got %h want %h", c - 1, q, expQ); end
      checks++; if (rise !== expR) begin errors++; $display("FAIL bound_rise e=%0d got %h want %h", c - 1, rise, expR); end
      checks++; if (fall !== expF) begin errors++; $display("FAIL bound_fall e=%0d got %h want %h", c - 1, fall, expF); end
    end
  endtask

  task automatic test_enable_hold();
    logic [3:0] expQ, expR;
    d_async = 4'h8;
    for (int c = 1; c <= 14; c++) begin
      tick(1);
      if (c == 5) en = 1'b0;
      if (c == 10) en = 1'b1;
      expQ = (c - 1 >= 11) ? 4'h8 : 4'h0;
      expR = (c - 1 == 11) ? 4'h8 : 4'h0;
      checks++; if (q !== expQ) begin errors++; $display("FAIL enhold_q e=%0d got %h want %h", c - 1, q, expQ); end
      checks++; if (rise !== expR) begin errors++; $display("FAIL enhold_rise e=%0d got %h want %h", c - 1, rise, expR); end
    end
    d_async = 4'h0;
    tick(10);
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL enhold_settle_q got %h want 0", q); end
  endtask

  task automatic test_mid_reset();
    logic [3:0] expQ, expR;
    d_async = 4'h1;
    tick(5);
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL midrst_pre_q got %h want 0", q); end
    rst = 1'b1;
    #1;
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL midrst_async_q got %h want 0", q); end
    for (int c = 1; c <= 3; c++) begin
      tick(1);
      checks++; if ((rise | fall) !== 4'h0) begin errors++; $display("FAIL midrst_pulse c=%0d got %h want 0", c, rise | fall); end
      checks++; if (any_edge !== 1'b0) begin errors++; $display("FAIL midrst_any c=%0d got %b want 0", c, any_edge); end
    end
    rst = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick(1);
      expQ = (c - 1 >= 6) ? 4'h1 : 4'h0;
      expR = (c - 1 == 6) ? 4'h1 : 4'h0;
      checks++; if (q !== expQ) begin errors++; $display("FAIL midrst_q e=%0d got %h want %h", c - 1, q, expQ); end
      checks++; if (rise !== expR) begin errors++; $display("FAIL midrst_rise e=%0d got %h want %h", c - 1, rise, expR); end
    end
`ifdef SYNC_FILTER_GLITCH_CNT_EN
    checks++; if (glitch_cnt !== 16'd0) begin errors++; $display("FAIL midrst_gcnt got %0d want 0", glitch_cnt); end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    en = 1'b1;
    d_async = 4'h0;
`ifdef SYNC_FILTER_GLITCH_CNT_EN
    glitch_clr = 1'b0;
`endif
    #1;
    test_reset();
    test_clean_step();
    test_glitch();
    test_boundary_pulse();
    test_enable_hold();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_filter_multi.md
Name: sync_filter_multi

Overview:
- Multi-channel input conditioner for asynchronous sensor and control lines entering the clk domain.
- Each channel has a configurable-depth flip-flop synchroniser, a stability (glitch) filter, and single-cycle rise/fall edge pulses.
- Sits between the board-level inputs and the motion-detection logic.
- Successor to the fixed 3-stage synchroniser: stage count, filter length and reset value are now parameters, and the filter and edge detection are new behaviour.

Parameters:
- N_CH, 16, number of independent channels.
- STAGES, 3, synchroniser depth; legal range ≥2; elaboration error if <2.
- FILT_LEN, 4, consecutive stable cycles required before an output changes; legal range ≥1; 1 = no filtering.
- RST_VAL, {N_CH{1'b0}}, reset value of the synchroniser stages and of q; per-channel bit.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  filter enable; synchroniser keeps running when low
- d_async  in  N_CH  raw asynchronous inputs
- q  out  N_CH  synchronised, filtered level
- rise  out  N_CH  one-cycle pulse when q goes 0→1
- fall  out  N_CH  one-cycle pulse when q goes 1→0
- any_edge  out  1  OR-reduction of rise|fall, registered with them

Behaviour:
- Reset (asynchronous, active-high):
  - all synchroniser stages and q = RST_VAL;
  - filter counters = 0;
  - rise = 0, fall = 0, any_edge = 0.
- Reset asserted mid-count discards the count; no pulse is generated on reset entry or exit.
- Synchroniser, per channel:
  - s[0] <= d_async; s[k] <= s[k-1] for k = 1..STAGES-1; synced = s[STAGES-1];
  - the chain is not gated by en.
- Filter, per channel: counter cnt, width CNT_W = max(1, clog2(FILT_LEN)). Each clk edge:
  - en = 0: cnt, q hold; rise/fall = 0.
  - synced == q: cnt <= 0; rise/fall = 0.
  - synced != q and cnt < FILT_LEN-1: cnt <= cnt+1; rise/fall = 0.
  - synced != q and cnt == FILT_LEN-1:
    - q <= synced; cnt <= 0;
    - rise <= synced, fall <= ~synced for one cycle, in the same cycle q updates.
- Latency: a clean step on d_async, first sampled at edge E, appears on q after edge E + STAGES + FILT_LEN - 1. Defaults: 6 edges after E.
- Acceptance rule:
  - a pulse is accepted only if synced holds its new value for FILT_LEN consecutive enabled edges;
  - shorter pulses are dropped completely (no partial effect).
- Channels are fully independent. Simultaneous edges on several channels produce simultaneous pulses. any_edge = |(rise|fall) of the same cycle.
- No wrap-around: cnt never exceeds FILT_LEN-1.
- en deasserted mid-count freezes cnt; counting resumes from the held value when en returns.

Optional Feature:
- Macro SYNC_FILTER_GLITCH_CNT_EN.
- Defined:
  - extra input glitch_clr (1 bit, synchronous) and output glitch_cnt (16 bits);
  - glitch_cnt increments, saturating at 16'hFFFF, on every enabled edge where some channel has synced == q and cnt != 0 (a rejected pulse), counting at most 1 per cycle;
  - glitch_clr has priority over increment;
  - reset value 0.
- Undefined: neither port exists, no counter logic is generated, and behaviour is otherwise identical.

Decomposition:
- Package sync_filter_pkg:
  - constant SYNC_MIN_STAGES = 2;
  - constant GLITCH_CNT_W = 16;
  - function cnt_width(FILT_LEN) returning max(1, clog2(FILT_LEN)).
- Sub-module sync_filter_ch: one channel (chain, counter, q, rise, fall, glitch flag), instantiated N_CH times in a generate loop.
- Top level holds any_edge and the optional glitch counter.

Test Plan:
All cases use N_CH=4, STAGES=3, FILT_LEN=4, RST_VAL=4'h0, en=1 unless stated.
- Reset entry/exit: hold rst with d_async=4'hF, release → q=4'h0 while reset; q=4'hF exactly 6 edges after the first post-reset edge; rise=4'hF for exactly one cycle; no fall.
- Clean step: d_async[0] 0→1 at edge E → q[0]=1 after edge E+6; rise[0] and any_edge high one cycle only; other channels quiet.
- Glitch rejection: d_async[1] high for 3 cycles → q, rise, fall all stay 0. With SYNC_FILTER_GLITCH_CNT_EN, glitch_cnt=1.
- Boundary pulse: d_async[2] high for exactly 4 cycles → rise[2] once, then fall[2] exactly 4 cycles later. q[2] is high for 4 cycles.
- Enable hold: d_async[3] steps high, en=0 for 5 cycles starting after 2 synced-different edges → q[3] holds 0 during en=0. q[3] rises 2 enabled edges after en returns.
- Mid-operation reset: assert rst while cnt=2 on channel 0 → q=RST_VAL and no pulses. After release, the full 6-edge latency applies again; glitch_cnt=0.
